// File: rtl/lbp_ctrl.sv
// Sequencing controller for the LBP engine: walks interior pixels in raster order,
// fetches 3x3 neighbourhoods (reusing two columns as the window slides) and strobes the datapath.
module lbp_ctrl #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    output logic          win_load,
    output logic [3:0]    win_slot,
    output logic          win_shift,
    output logic          calc_en,
    output logic [AW-1:0] lbp_addr,
    output logic          lbp_valid,
    output logic          finish
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CALC,
        WRITE,
        SHIFT,
        LOAD3,
        DONE
    } state_t;

    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 2);
    localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 2);

    state_t        state, state_n;
    logic [AW-1:0] x, y, x_n, y_n;
    logic [AW-1:0] row, col, row_n, col_n;
    logic [3:0]    slot_n;
    logic          req_n;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] r, input logic [AW-1:0] c);
        return r * AW'(IMG_W) + c;
    endfunction

    // win_slot/row/col describe the read currently pending; a read completes in any
    // cycle where gray_req is high, otherwise it is held and reissued.
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        row_n   = row;
        col_n   = col;
        slot_n  = win_slot;
        case (state)
            IDLE: begin
                if (gray_ready) begin
                    state_n = FILL;
                    slot_n  = 4'd0;
                    row_n   = y - ONE;
                    col_n   = x - ONE;
                end
            end
            FILL: begin
                if (gray_req) begin
                    if (win_slot == 4'd8) begin
                        state_n = CALC;
                    end else begin
                        slot_n = win_slot + 4'd1;
                        if (col == x + ONE) begin
                            col_n = x - ONE;
                            row_n = row + ONE;
                        end else begin
                            col_n = col + ONE;
                        end
                    end
                end
            end
            CALC: state_n = WRITE;
            WRITE: begin
                if (x < X_LAST) begin
                    x_n     = x + ONE;
                    state_n = SHIFT;
                end else if (y < Y_LAST) begin
                    x_n     = ONE;
                    y_n     = y + ONE;
                    state_n = FILL;
                    slot_n  = 4'd0;
                    row_n   = y;
                    col_n   = '0;
                end else begin
                    state_n = DONE;
                end
            end
            SHIFT: begin
                state_n = LOAD3;
                slot_n  = 4'd2;
                row_n   = y - ONE;
                col_n   = x + ONE;
            end
            LOAD3: begin
                if (gray_req) begin
                    if (win_slot == 4'd8) begin
                        state_n = CALC;
                    end else begin
                        slot_n = win_slot + 4'd3;
                        row_n  = row + ONE;
                    end
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
        req_n = gray_ready && (state_n == FILL || state_n == LOAD3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x         <= ONE;
            y         <= ONE;
            row       <= '0;
            col       <= '0;
            gray_req  <= 1'b0;
            gray_addr <= '0;
            win_load  <= 1'b0;
            win_slot  <= 4'd0;
            win_shift <= 1'b0;
            calc_en   <= 1'b0;
            lbp_addr  <= '0;
            lbp_valid <= 1'b0;
            finish    <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            row       <= row_n;
            col       <= col_n;
            gray_req  <= req_n;
            win_load  <= req_n;
            gray_addr <= pix_addr(row_n, col_n);
            win_slot  <= slot_n;
            win_shift <= (state_n == SHIFT);
            calc_en   <= (state_n == CALC);
            lbp_valid <= (state_n == WRITE);
            if (state_n == WRITE) begin
                lbp_addr <= pix_addr(y, x);
            end
            finish    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_lbp_ctrl.sv
// Bench for lbp_ctrl: acts as gray memory and window datapath, and checks reads, windows,
// LBP results, write order/timing, stalls and asynchronous reset against an image-level model.
module tb_lbp_ctrl;

    localparam int W       = 10;
    localparam int H       = 7;
    localparam int AW      = 7;
    localparam int NPIX    = (W - 2) * (H - 2);
    localparam int ROW_CYC = 11 + 6 * (W - 3);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gray_ready = 1'b0;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          win_load;
    logic [3:0]    win_slot;
    logic          win_shift;
    logic          calc_en;
    logic [AW-1:0] lbp_addr;
    logic          lbp_valid;
    logic          finish;

    lbp_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .win_load   (win_load),
        .win_slot   (win_slot),
        .win_shift  (win_shift),
        .calc_en    (calc_en),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] mem [W*H];
    logic [7:0] win [9];
    logic [7:0] lbp_latched;
    int         ex, ey, pix_idx, cyc, t0, last_valid_cyc;
    bit         seen_req, nostall;

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] all_outs();
        return {gray_req, gray_addr, win_load, win_slot, win_shift, calc_en, lbp_addr, lbp_valid, finish};
    endfunction

    function automatic logic [71:0] neigh(input int cx, input int cy);
        logic [71:0] p;
        p = '0;
        for (int s = 0; s < 9; s++) p[8*s +: 8] = mem[(cy - 1 + s / 3) * W + (cx - 1 + s % 3)];
        return p;
    endfunction

    // LBP code: one bit per neighbour in slot order, set when neighbour >= centre
    function automatic logic [7:0] lbp_of(input logic [71:0] p);
        logic [7:0] r;
        int k;
        r = '0;
        k = 0;
        for (int s = 0; s < 9; s++) begin
            if (s != 4) begin
                r[k] = (p[8*s +: 8] >= p[39:32]);
                k++;
            end
        end
        return r;
    endfunction

    task automatic sampleCycle(input bit rdy_prev);
        logic [71:0] wp;
        int s;
        int exp_addr;
        @(negedge clk);
        cyc++;
        checkOutput("finish", finish, (pix_idx == NPIX && last_valid_cyc < cyc));
        checkOutput("load_eq_req", win_load, gray_req);
        if (!rdy_prev) checkOutput("req_while_not_ready", gray_req, 0);
        if (pix_idx >= NPIX) checkOutput("activity_after_done", {gray_req, win_shift, calc_en, lbp_valid}, 0);
        if (gray_req && pix_idx < NPIX) begin
            if (!seen_req) begin
                seen_req = 1'b1;
                t0 = cyc;
            end
            s = int'(win_slot);
            checkOutput("slot_range", s < 9, 1);
            checkOutput("rd_in_range", int'(gray_addr) < W * H, 1);
            if (s < 9) begin
                exp_addr = (ey - 1 + s / 3) * W + (ex - 1 + s % 3);
                checkOutput("rd_addr", gray_addr, exp_addr);
                if (int'(gray_addr) < W * H) win[s] = mem[gray_addr];
            end
        end
        if (win_shift) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]     = win[3*r + 1];
                win[3*r + 1] = win[3*r + 2];
            end
        end
        if (calc_en && pix_idx < NPIX) begin
            for (int k = 0; k < 9; k++) wp[8*k +: 8] = win[k];
            checkOutput("window", wp, neigh(ex, ey));
            lbp_latched = lbp_of(wp);
        end
        if (lbp_valid && pix_idx < NPIX) begin
            checkOutput("wr_addr", lbp_addr, ey * W + ex);
            checkOutput("pixel", lbp_latched, lbp_of(neigh(ex, ey)));
            if (nostall) checkOutput("wr_cycle", cyc - t0, (ey - 1) * ROW_CYC + 10 + 6 * (ex - 1));
            pix_idx++;
            last_valid_cyc = cyc;
            if (ex < W - 2) ex++;
            else begin
                ex = 1;
                ey++;
            end
        end
    endtask

    task automatic applyStimulus(input bit rdy);
        gray_ready = rdy;
        sampleCycle(rdy);
    endtask

    task automatic doReset();
        reset = 1'b1;
        gray_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        ex = 1;
        ey = 1;
        pix_idx = 0;
        seen_req = 1'b0;
        last_valid_cyc = 0;
    endtask

    task automatic runToFinish(input bit rnd, input int budget);
        int n;
        n = 0;
        while (!finish && n < budget) begin
            applyStimulus(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            n++;
        end
        checkOutput("finish_reached", finish, 1);
        checkOutput("write_count", pix_idx, NPIX);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    endtask

    initial begin
        int n;
        cyc = 0;
        t0 = 0;
        nostall = 1'b0;
        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom_range(0, 7));
        for (int i = 0; i < 9; i++) win[i] = '0;

        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        checkOutput("idle_no_req", gray_req, 0);

        // Stall-free frame: exact write timing and total frame length
        nostall = 1'b1;
        runToFinish(1'b0, 2000);
        checkOutput("frame_cycles", last_valid_cyc - t0 + 1, (H - 2) * ROW_CYC);
        nostall = 1'b0;

        // Hold gray_ready low while slot 4 of the first fill is pending
        doReset();
        n = 0;
        applyStimulus(1'b1);
        while (!(gray_req && win_slot == 4'd3) && n < 50) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("reach_slot3", (gray_req && win_slot == 4'd3), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0);
            checkOutput("stall_req_low", gray_req, 0);
            checkOutput("stall_addr_held", gray_addr, W + 1);
            checkOutput("stall_slot_held", win_slot, 4);
        end
        applyStimulus(1'b1);
        checkOutput("resume_req", gray_req, 1);
        checkOutput("resume_slot", win_slot, 4);
        checkOutput("resume_addr", gray_addr, W + 1);
        runToFinish(1'b1, 5000);

        // Asynchronous reset between edges while a column load is in progress
        doReset();
        n = 0;
        applyStimulus(1'b1);
        while (!(gray_req && pix_idx >= 1 && win_slot == 4'd5) && n < 100) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("reach_load3", (gray_req && pix_idx >= 1 && win_slot == 4'd5), 1);
        #2 reset = 1'b1;
        #1 checkOutput("async_clear", all_outs(), 0);
        doReset();
        applyStimulus(1'b1);
        checkOutput("restart_req", gray_req, 1);
        checkOutput("restart_addr", gray_addr, 0);
        checkOutput("restart_slot", win_slot, 0);
        runToFinish(1'b1, 5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
